// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control unit.
// Sequences one instruction through FETCH/DECODE/EXEC/MEM/WB and drives every
// datapath select. Outputs are combinational from the state and the IR.
// Optional build macro CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        br_equal,
  input  logic        br_less,
  output logic        imem_req,
  output logic        ir_en,
  output logic        opa_sel,
  output logic        opb_sel,
  output logic [3:0]  alu_op,
  output logic        br_unsigned,
  output logic        dmem_req,
  output logic        dmem_wren,
  output logic        rd_wren,
  output logic [1:0]  wb_sel,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_BRANCH,
    C_ILL
  } cls_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_t;

  state_t     state, state_nxt;
  cls_t       cls;
  alu_t       x_alu;
  logic       x_opa;
  logic       x_opb;
  logic       taken;
  logic [2:0] funct3;
  logic       is_jump;
  logic       unused_instr_bits;

  assign funct3            = instr[14:12];
  assign is_jump           = (cls == C_JAL) || (cls == C_JALR);
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Opcode classification; LOAD/STORE/BRANCH with non-RV32I funct3 are illegal.
  always_comb begin
    cls = C_ILL;
    case (instr[6:0])
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_I;
      7'b0000011: cls = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                        ? C_ILL : C_LOAD;
      7'b0100011: cls = funct3[2] || (funct3 == 3'b011) ? C_ILL : C_STORE;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b1100011: cls = (funct3 == 3'b010 || funct3 == 3'b011) ? C_ILL : C_BRANCH;
      default:    cls = C_ILL;
    endcase
  end

  // ALU operand and operation selects shared by EXEC and MEM.
  always_comb begin
    x_opa = (cls == C_AUIPC) || (cls == C_JAL) || (cls == C_BRANCH);
    x_opb = (cls != C_R);
    x_alu = ALU_ADD;
    if (cls == C_LUI) begin
      x_alu = ALU_PASSB;
    end else if (cls == C_R || cls == C_I) begin
      case (funct3)
        3'b000:  x_alu = (cls == C_R && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b001:  x_alu = ALU_SLL;
        3'b010:  x_alu = ALU_SLT;
        3'b011:  x_alu = ALU_SLTU;
        3'b100:  x_alu = ALU_XOR;
        3'b101:  x_alu = instr[30] ? ALU_SRA : ALU_SRL;
        3'b110:  x_alu = ALU_OR;
        default: x_alu = ALU_AND;
      endcase
    end
  end

  // Branch-taken decision from comparator flags.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = br_equal;
      3'b001:          taken = !br_equal;
      3'b100, 3'b110:  taken = br_less;
      3'b101, 3'b111:  taken = !br_less;
      default:         taken = 1'b0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    ir_en       = 1'b0;
    opa_sel     = 1'b0;
    opb_sel     = 1'b0;
    alu_op      = ALU_ADD;
    br_unsigned = 1'b0;
    dmem_req    = 1'b0;
    dmem_wren   = 1'b0;
    rd_wren     = 1'b0;
    wb_sel      = 2'd0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          illegal   = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        opa_sel = x_opa;
        opb_sel = x_opb;
        alu_op  = x_alu;
        case (cls)
          C_BRANCH: begin
            br_unsigned = funct3[1];
            pc_en       = 1'b1;
            pc_sel      = taken;
            state_nxt   = S_FETCH;
          end
          C_JAL, C_JALR: begin
            pc_en     = 1'b1;
            pc_sel    = 1'b1;
            state_nxt = S_WB;
          end
          C_LOAD, C_STORE: state_nxt = S_MEM;
          C_ILL:           state_nxt = S_FETCH;
          default:         state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        opa_sel   = x_opa;
        opb_sel   = x_opb;
        alu_op    = x_alu;
        dmem_req  = 1'b1;
        dmem_wren = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_en     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rd_wren   = 1'b1;
        wb_sel    = (cls == C_LOAD) ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        pc_en     = !is_jump;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

`ifdef CTRL_PERF_CNT_EN
  // Free-running cycle counter and retired-instruction counter (illegal excluded).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_en && !illegal) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized check of multicycle_ctrl against
// a per-instruction cycle-sequence model. Define CTRL_PERF_CNT_EN to also
// cover the performance counters.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, br_equal, br_less;
  logic        imem_req, ir_en, opa_sel, opb_sel, br_unsigned;
  logic [3:0]  alu_op;
  logic        dmem_req, dmem_wren, rd_wren, pc_en, pc_sel, illegal;
  logic [1:0]  wb_sel;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .br_equal(br_equal), .br_less(br_less),
    .imem_req(imem_req), .ir_en(ir_en), .opa_sel(opa_sel), .opb_sel(opb_sel),
    .alu_op(alu_op), .br_unsigned(br_unsigned), .dmem_req(dmem_req),
    .dmem_wren(dmem_wren), .rd_wren(rd_wren), .wb_sel(wb_sel),
    .pc_en(pc_en), .pc_sel(pc_sel), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic       imem_req;
    logic       ir_en;
    logic       opa_sel;
    logic       opb_sel;
    logic [3:0] alu_op;
    logic       br_unsigned;
    logic       dmem_req;
    logic       dmem_wren;
    logic       rd_wren;
    logic [1:0] wb_sel;
    logic       pc_en;
    logic       pc_sel;
    logic       illegal;
  } ov_t;

  typedef struct {
    logic        ir, dr, beq, blt, rst;
    logic [31:0] ins;
    ov_t         exp;
    string       tag;
  } cyc_t;

  cyc_t        q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned m_cyc   = 0;
  int unsigned m_ret   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction class from the RV32I opcode and funct3 legality tables.
  function automatic string classify(logic [31:0] i);
    logic [2:0] f3;
    logic [7:0] ld_ok, st_ok, br_ok;
    f3 = i[14:12];
    ld_ok = 8'h37; st_ok = 8'h07; br_ok = 8'hF3;
    case (i[6:0])
      7'h33:   return "R";
      7'h13:   return "I";
      7'h03:   return ld_ok[f3] ? "LD" : "ILL";
      7'h23:   return st_ok[f3] ? "ST" : "ILL";
      7'h37:   return "LUI";
      7'h17:   return "AUIPC";
      7'h6F:   return "JAL";
      7'h67:   return "JALR";
      7'h63:   return br_ok[f3] ? "BR" : "ILL";
      default: return "ILL";
    endcase
  endfunction

  function automatic logic [3:0] alu_model(logic [31:0] i, string k);
    int tab[8];
    int op;
    int f3;
    tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = int'(i[14:12]);
    if (k == "LUI") return 4'd10;
    if (k != "R" && k != "I") return 4'd0;
    op = tab[f3];
    if (k == "R" && i[30] && f3 == 0) op = 1;
    if (i[30] && f3 == 5) op = 7;
    return 4'(op);
  endfunction

  function automatic cyc_t mk(logic ir, logic dr, logic [31:0] ins, ov_t v, string tag);
    cyc_t c;
    c.ir = ir; c.dr = dr; c.beq = rb(); c.blt = rb(); c.rst = 1'b1;
    c.ins = ins; c.exp = v; c.tag = tag;
    return c;
  endfunction

  // Expected cycle sequence of one instruction, appended to q.
  task automatic gen(input logic [31:0] ins, input int unsigned fw, input int unsigned mw,
                     input logic beq, input logic blt, input string nm);
    string      k;
    ov_t        v, e;
    cyc_t       c;
    logic [2:0] f3;
    logic       jump;
    k = classify(ins);
    f3 = ins[14:12];
    jump = (k == "JAL") || (k == "JALR");
    for (int unsigned i = 0; i < fw; i++) begin
      v = '0; v.imem_req = 1'b1;
      q.push_back(mk(1'b0, rb(), $urandom, v, {nm, "/fetch_wait"}));
    end
    v = '0; v.imem_req = 1'b1; v.ir_en = 1'b1;
    q.push_back(mk(1'b1, rb(), $urandom, v, {nm, "/fetch"}));
    v = '0;
    if (k == "ILL") begin
      v.illegal = 1'b1; v.pc_en = 1'b1;
      q.push_back(mk(rb(), rb(), ins, v, {nm, "/decode_ill"}));
      return;
    end
    q.push_back(mk(rb(), rb(), ins, v, {nm, "/decode"}));
    e = '0;
    e.opb_sel = (k != "R");
    e.opa_sel = (k == "AUIPC") || (k == "JAL") || (k == "BR");
    e.alu_op  = alu_model(ins, k);
    if (k == "BR") begin
      e.br_unsigned = f3[1];
      e.pc_en       = 1'b1;
      e.pc_sel      = (f3[2] ? blt : beq) ^ f3[0];
      c = mk(rb(), rb(), ins, e, {nm, "/exec_br"});
      c.beq = beq; c.blt = blt;
      q.push_back(c);
      return;
    end
    if (jump) begin
      e.pc_en = 1'b1; e.pc_sel = 1'b1;
    end
    q.push_back(mk(rb(), rb(), ins, e, {nm, "/exec"}));
    if (k == "LD" || k == "ST") begin
      v = e; v.dmem_req = 1'b1; v.dmem_wren = (k == "ST");
      for (int unsigned i = 0; i < mw; i++)
        q.push_back(mk(rb(), 1'b0, ins, v, {nm, "/mem_wait"}));
      if (k == "ST") v.pc_en = 1'b1;
      q.push_back(mk(rb(), 1'b1, ins, v, {nm, "/mem"}));
      if (k == "ST") return;
    end
    v = '0;
    v.rd_wren = 1'b1;
    v.wb_sel  = (k == "LD") ? 2'd1 : (jump ? 2'd2 : 2'd0);
    v.pc_en   = !jump;
    q.push_back(mk(rb(), rb(), ins, v, {nm, "/wb"}));
  endtask

  // Drive one cycle, sample at the falling edge, advance the counter model.
  task automatic play(input cyc_t c, inout int pcs);
    ov_t got;
    rst_n = c.rst; imem_ready = c.ir; dmem_ready = c.dr;
    br_equal = c.beq; br_less = c.blt; instr = c.ins;
    @(negedge clk);
    got = {imem_req, ir_en, opa_sel, opb_sel, alu_op, br_unsigned, dmem_req,
           dmem_wren, rd_wren, wb_sel, pc_en, pc_sel, illegal};
    check(c.tag, 32'(got), 32'(c.exp));
`ifdef CTRL_PERF_CNT_EN
    check({c.tag, "/cycle_cnt"}, cycle_cnt, m_cyc);
    check({c.tag, "/instret_cnt"}, instret_cnt, m_ret);
`endif
    pcs += int'(pc_en);
    if (c.rst) begin
      m_cyc++;
      if (c.exp.pc_en && !c.exp.illegal) m_ret++;
    end else begin
      m_cyc = 0; m_ret = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [31:0] ins, input int unsigned fw, input int unsigned mw,
                     input logic beq, input logic blt, input string nm);
    int pcs;
    pcs = 0;
    q.delete();
    gen(ins, fw, mw, beq, blt, nm);
    foreach (q[i]) play(q[i], pcs);
    check({nm, "/pc_en_pulses"}, 32'(pcs), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ov_t         fv;
    int          pcs;
    logic [6:0]  ops[9];
    logic [6:0]  ill_ops[4];
    logic [31:0] ins;
    int unsigned pick;
    ops     = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
    ill_ops = '{7'h7F, 7'h00, 7'h0F, 7'h73};

    rst_n = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    br_equal = 1'b0; br_less = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    fv = '0; fv.imem_req = 1'b1;
    check("reset_outputs", 32'({imem_req, ir_en, opa_sel, opb_sel, alu_op, br_unsigned,
          dmem_req, dmem_wren, rd_wren, wb_sel, pc_en, pc_sel, illegal}), 32'(fv));
`ifdef CTRL_PERF_CNT_EN
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instret_cnt", instret_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    m_cyc = 0; m_ret = 0;

    run(32'h00500093, 0, 0, 1'b0, 1'b0, "addi");
    run(32'h002081B3, 0, 0, 1'b0, 1'b0, "add");
    run(32'h402081B3, 0, 0, 1'b0, 1'b0, "sub");
    run(32'h0000A283, 0, 2, 1'b0, 1'b0, "lw_wait2");
    run(32'h00208463, 0, 0, 1'b1, 1'b0, "beq_taken");
    run(32'h00208463, 0, 0, 1'b0, 1'b1, "beq_not_taken");
    run(32'h0000007F, 0, 0, 1'b0, 1'b0, "illegal_7f");
    run(32'h0000A023, 1, 1, 1'b0, 1'b0, "sw_waits");

    // Reset during EXEC of ADD, then idle fetch cycles that must stay quiet.
    q.delete();
    gen(32'h002081B3, 0, 0, 1'b0, 1'b0, "rst_mid");
    q[2].rst = 1'b0;
    q.delete(3);
    for (int i = 0; i < 3; i++) begin
      fv = '0; fv.imem_req = 1'b1;
      q.push_back(mk(1'b0, rb(), $urandom, fv, "rst_mid/after_reset"));
    end
    pcs = 0;
    foreach (q[i]) play(q[i], pcs);

    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 10);
      ins = $urandom;
      if (pick < 9) ins[6:0] = ops[pick];
      else          ins[6:0] = ill_ops[$urandom_range(0, 3)];
      run(ins, $urandom_range(0, 2), $urandom_range(0, 2), rb(), rb(),
          $sformatf("rnd%0d_%08h", n, ins));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
